// File: rtl/board_controller_pkg.sv
// Shared definitions for the tic-tac-toe board controller and its consumers.
package board_controller_pkg;

    typedef enum logic [1:0] {
        PLAY,
        EVAL,
        DRAW,
        OVER
    } state_t;

    // Cell codes in the packed grid
    localparam logic [1:0] EMPTY  = 2'b00;
    localparam logic [1:0] CELL_X = 2'b01;
    localparam logic [1:0] CELL_O = 2'b10;

    // Game status codes
    localparam logic [1:0] STATUS_PLAYING = 2'b00;
    localparam logic [1:0] STATUS_X_WINS  = 2'b01;
    localparam logic [1:0] STATUS_O_WINS  = 2'b10;
    localparam logic [1:0] STATUS_DRAW    = 2'b11;

    // Winning line identifiers
    localparam logic [3:0] WIN_ROW0 = 4'd0;
    localparam logic [3:0] WIN_ROW1 = 4'd1;
    localparam logic [3:0] WIN_ROW2 = 4'd2;
    localparam logic [3:0] WIN_COL0 = 4'd3;
    localparam logic [3:0] WIN_COL1 = 4'd4;
    localparam logic [3:0] WIN_COL2 = 4'd5;
    localparam logic [3:0] WIN_DIAG = 4'd6;
    localparam logic [3:0] WIN_ANTI = 4'd7;
    localparam logic [3:0] WIN_NONE = 4'd15;

    localparam logic [3:0] MAX_MOVES = 4'd9;

    // Code written into a cell by the side to move
    function automatic logic [1:0] cell_code(input logic side);
        return side ? CELL_O : CELL_X;
    endfunction

    // Status reported when the given cell code owns a completed line
    function automatic logic [1:0] status_for(input logic [1:0] winner);
        return (winner == CELL_O) ? STATUS_O_WINS : STATUS_X_WINS;
    endfunction

    // Two-bit cell k (k = 3*row + col) of a packed grid
    function automatic logic [1:0] cell_at(input logic [17:0] g, input logic [3:0] k);
        return g[{k, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/board_controller_if.sv
// Move / board / renderer handshake bundle of the board controller.
interface board_controller_if;
    logic        move_valid;
    logic [1:0]  move_row;
    logic [1:0]  move_col;
    logic        move_ready;
    logic        new_game;
    logic [17:0] grid;
    logic        turn;
    logic [1:0]  status;
    logic [3:0]  win_line;
    logic        move_err;
    logic        draw_req;
    logic        draw_done;

    // Controller side
    modport slave (
        input  move_valid, move_row, move_col, new_game, draw_done,
        output move_ready, grid, turn, status, win_line, move_err, draw_req
    );

    // Player / renderer side
    modport master (
        output move_valid, move_row, move_col, new_game, draw_done,
        input  move_ready, grid, turn, status, win_line, move_err, draw_req
    );
endinterface

// File: rtl/board_controller_line_checker.sv
// Combinational scan of all eight lines of a packed 3x3 grid.
module line_checker
    import board_controller_pkg::*;
(
    input  logic [17:0] grid,
    output logic        win,
    output logic [1:0]  winner,
    output logic [3:0]  win_line
);

    // Cell indices {a, b, c} forming line l
    function automatic logic [11:0] line_cells(input logic [3:0] l);
        case (l)
            WIN_ROW0: return {4'd0, 4'd1, 4'd2};
            WIN_ROW1: return {4'd3, 4'd4, 4'd5};
            WIN_ROW2: return {4'd6, 4'd7, 4'd8};
            WIN_COL0: return {4'd0, 4'd3, 4'd6};
            WIN_COL1: return {4'd1, 4'd4, 4'd7};
            WIN_COL2: return {4'd2, 4'd5, 4'd8};
            WIN_DIAG: return {4'd0, 4'd4, 4'd8};
            WIN_ANTI: return {4'd2, 4'd4, 4'd6};
            default:  return {4'd2, 4'd4, 4'd6};
        endcase
    endfunction

    // Scan from line 7 down to 0 so the lowest matching index is reported
    always_comb begin
        logic [3:0]  l;
        logic [11:0] cells;
        logic [1:0]  ca, cb, cc;
        win      = 1'b0;
        winner   = EMPTY;
        win_line = WIN_NONE;
        l        = '0;
        cells    = '0;
        ca       = EMPTY;
        cb       = EMPTY;
        cc       = EMPTY;
        for (int unsigned n = 0; n < 8; n++) begin
            l     = 4'(7 - n);
            cells = line_cells(l);
            ca    = cell_at(grid, cells[11:8]);
            cb    = cell_at(grid, cells[7:4]);
            cc    = cell_at(grid, cells[3:0]);
            if (ca != EMPTY && ca == cb && cb == cc) begin
                win      = 1'b1;
                winner   = ca;
                win_line = l;
            end
        end
    end

endmodule

// File: rtl/board_controller.sv
// Tic-tac-toe game-state owner: accepts moves, evaluates the board and
// hands every board change to the renderer before accepting the next move.
module board_controller
    import board_controller_pkg::*;
#(
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    board_controller_if.slave  bus
);

    state_t      state, state_n;
    logic [17:0] grid_q, grid_n;
    logic        turn_q, turn_n;
    logic [1:0]  status_q, status_n;
    logic [3:0]  win_q, win_n;
    logic [3:0]  count_q, count_n;
    logic        err_q, err_n;

    logic        chk_win;
    logic [1:0]  chk_winner;
    logic [3:0]  chk_line;

    logic        in_range;
    logic [3:0]  cell_idx;
    logic        illegal;

    line_checker u_line_checker (
        .grid     (grid_q),
        .win      (chk_win),
        .winner   (chk_winner),
        .win_line (chk_line)
    );

    // Target cell decode and legality of the presented move
    always_comb begin
        in_range = (bus.move_row <= 2'd2) && (bus.move_col <= 2'd2);
        cell_idx = in_range ? ({2'b00, bus.move_row} * 4'd3 + {2'b00, bus.move_col}) : '0;
        illegal  = !in_range || (cell_at(grid_q, cell_idx) != EMPTY);
    end

    // State and board registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= PLAY;
            grid_q   <= '0;
            turn_q   <= FIRST_PLAYER;
            status_q <= STATUS_PLAYING;
            win_q    <= WIN_NONE;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_n;
            grid_q   <= grid_n;
            turn_q   <= turn_n;
            status_q <= status_n;
            win_q    <= win_n;
            count_q  <= count_n;
            err_q    <= err_n;
        end
    end

    // Next-state and board update logic
    always_comb begin
        state_n  = state;
        grid_n   = grid_q;
        turn_n   = turn_q;
        status_n = status_q;
        win_n    = win_q;
        count_n  = count_q;
        err_n    = 1'b0;
        case (state)
            PLAY: begin
                if (bus.new_game) begin
                    grid_n   = '0;
                    turn_n   = FIRST_PLAYER;
                    status_n = STATUS_PLAYING;
                    win_n    = WIN_NONE;
                    count_n  = '0;
                    state_n  = DRAW;
                end else if (bus.move_valid) begin
                    if (illegal) begin
                        err_n = 1'b1;
                    end else begin
                        grid_n[{cell_idx, 1'b0} +: 2] = cell_code(turn_q);
                        count_n = (count_q == MAX_MOVES) ? count_q : count_q + 4'd1;
                        state_n = EVAL;
                    end
                end
            end
            EVAL: begin
                if (chk_win) begin
                    status_n = status_for(chk_winner);
                    win_n    = chk_line;
                end else if (count_q == MAX_MOVES) begin
                    status_n = STATUS_DRAW;
                end else begin
                    turn_n = ~turn_q;
                end
                state_n = DRAW;
            end
            DRAW: begin
                if (bus.draw_done) begin
                    state_n = (status_q == STATUS_PLAYING) ? PLAY : OVER;
                end
            end
            OVER: begin
                if (bus.new_game) begin
                    grid_n   = '0;
                    turn_n   = FIRST_PLAYER;
                    status_n = STATUS_PLAYING;
                    win_n    = WIN_NONE;
                    count_n  = '0;
                    state_n  = DRAW;
                end
            end
            default: state_n = PLAY;
        endcase
    end

    assign bus.move_ready = (state == PLAY);
    assign bus.draw_req   = (state == DRAW);
    assign bus.grid       = grid_q;
    assign bus.turn       = turn_q;
    assign bus.status     = status_q;
    assign bus.win_line   = win_q;
    assign bus.move_err   = err_q;

endmodule

// File: tb/tb_board_controller.sv
// Scoreboard bench for board_controller against a board-level game model.
module tb_board_controller;

    localparam logic FP = 1'b0;

    logic clk = 1'b0;
    logic reset;

    board_controller_if bus();

    board_controller #(.FIRST_PLAYER(FP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic [17:0] grid;
        logic        turn;
        logic [1:0]  status;
        logic [3:0]  win;
    } draw_exp_t;

    typedef struct {
        int          stamp;
        logic [17:0] grid;
        logic        turn;
    } err_exp_t;

    draw_exp_t draw_q[$];
    err_exp_t  err_q[$];

    int         b[3][3];
    logic       m_turn;
    logic [1:0] m_status;
    logic [3:0] m_win;
    int         m_count;
    int         seq[$];

    function automatic logic [17:0] model_grid();
        logic [17:0] g = '0;
        for (int k = 0; k < 9; k++) g[2*k +: 2] = 2'(b[k/3][k%3]);
        return g;
    endfunction

    function void model_new_game();
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) b[r][c] = 0;
        m_turn = FP; m_status = 2'd0; m_win = 4'd15; m_count = 0;
    endfunction

    function void push_draw();
        draw_exp_t e;
        e.grid = model_grid(); e.turn = m_turn; e.status = m_status; e.win = m_win;
        draw_q.push_back(e);
    endfunction

    // Owner (1 = X, 2 = O) of line l, or 0 if not three of a kind
    function automatic int line_owner(input int l);
        int v[3];
        int rr, cc;
        for (int p = 0; p < 3; p++) begin
            if (l < 3)       begin rr = l; cc = p;     end
            else if (l < 6)  begin rr = p; cc = l - 3; end
            else if (l == 6) begin rr = p; cc = p;     end
            else             begin rr = p; cc = 2 - p; end
            v[p] = b[rr][cc];
        end
        return (v[0] != 0 && v[0] == v[1] && v[1] == v[2]) ? v[0] : 0;
    endfunction

    function automatic bit model_move(input int r, input int c);
        err_exp_t e;
        bit found = 0;
        if (m_status != 2'd0) return 0;
        if (r > 2 || c > 2 || b[r][c] != 0) begin
            e.stamp = cyc + 1; e.grid = model_grid(); e.turn = m_turn;
            err_q.push_back(e);
            return 0;
        end
        b[r][c] = m_turn ? 2 : 1;
        m_count++;
        for (int l = 0; l < 8; l++) begin
            if (!found && line_owner(l) != 0) begin
                found = 1; m_status = 2'(line_owner(l)); m_win = 4'(l);
            end
        end
        if (!found) begin
            if (m_count == 9) m_status = 2'd3;
            else m_turn = ~m_turn;
        end
        push_draw();
        return 1;
    endfunction

    // ---------------- monitor ----------------
    logic      prev_req = 1'b0;
    draw_exp_t de;
    err_exp_t  ee;

    always @(negedge clk) begin
        if (bus.draw_req && !prev_req) begin
            if (draw_q.size() == 0) check("draw_req_unexpected", bus.draw_req, 0);
            else begin
                de = draw_q.pop_front();
                check("draw_grid", bus.grid, de.grid);
                check("draw_turn", bus.turn, de.turn);
                check("draw_status", bus.status, de.status);
                check("draw_win_line", bus.win_line, de.win);
            end
        end
        prev_req = bus.draw_req;
        if (err_q.size() != 0 && err_q[0].stamp == cyc) begin
            ee = err_q.pop_front();
            check("move_err", bus.move_err, 1);
            check("err_grid", bus.grid, ee.grid);
            check("err_turn", bus.turn, ee.turn);
        end else if (bus.move_err) begin
            check("move_err_unexpected", bus.move_err, 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue_move(input int r, input int c, output bit legal);
        logic [1:0] old_status;
        @(negedge clk);
        check("move_ready", bus.move_ready, m_status == 2'd0);
        old_status     = m_status;
        bus.move_valid = 1'b1;
        bus.move_row   = 2'(r);
        bus.move_col   = 2'(c);
        legal          = model_move(r, c);
        @(negedge clk);
        bus.move_valid = 1'b0;
        check("grid_after_move", bus.grid, model_grid());
        check("status_before_eval", bus.status, old_status);
    endtask

    task automatic wait_draw_req();
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = bus.draw_req;
        end
        if (!seen) check("draw_req_timeout", bus.draw_req, 1);
    endtask

    task automatic serve_draw(input int delay);
        wait_draw_req();
        repeat (delay) @(negedge clk);
        bus.draw_done = 1'b1;
        @(negedge clk);
        bus.draw_done = 1'b0;
        check("ready_after_draw", bus.move_ready, m_status == 2'd0);
        check("draw_req_after_draw", bus.draw_req, 0);
    endtask

    task automatic start_game();
        @(negedge clk);
        bus.new_game = 1'b1;
        model_new_game();
        push_draw();
        @(negedge clk);
        bus.new_game = 1'b0;
        check("grid_cleared", bus.grid, model_grid());
        serve_draw($urandom_range(0, 3));
    endtask

    task automatic play_seq(input int delay);
        bit legal;
        foreach (seq[i]) begin
            issue_move(seq[i] / 4, seq[i] % 4, legal);
            if (legal) serve_draw(delay);
        end
    endtask

    initial begin
        bit legal;
        reset = 1'b1;
        bus.move_valid = 1'b0; bus.move_row = '0; bus.move_col = '0;
        bus.new_game = 1'b0; bus.draw_done = 1'b0;
        model_new_game();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_grid", bus.grid, 0);
        check("rst_turn", bus.turn, FP);
        check("rst_status", bus.status, 0);
        check("rst_win_line", bus.win_line, 15);
        check("rst_move_ready", bus.move_ready, 1);
        check("rst_draw_req", bus.draw_req, 0);
        check("rst_move_err", bus.move_err, 0);

        // draw_done outside DRAW has no effect
        bus.draw_done = 1'b1;
        @(negedge clk);
        bus.draw_done = 1'b0;
        check("stray_done_ready", bus.move_ready, 1);
        check("stray_done_req", bus.draw_req, 0);

        // X wins on row 0
        seq = '{0, 5, 1, 10, 2};
        play_seq(5);
        check("x_row_status", bus.status, 1);
        check("x_row_win_line", bus.win_line, 0);
        check("over_move_ready", bus.move_ready, 0);
        issue_move(2, 2, legal);

        // illegal moves: occupied, out of range, back-to-back
        start_game();
        issue_move(1, 1, legal);
        if (legal) serve_draw(1);
        issue_move(1, 1, legal);
        issue_move(3, 0, legal);
        check("turn_after_err", bus.turn, m_turn);
        @(negedge clk);
        bus.move_valid = 1'b1; bus.move_row = 2'd1; bus.move_col = 2'd1;
        legal = model_move(1, 1);
        @(negedge clk);
        bus.move_row = 2'd0; bus.move_col = 2'd3;
        legal = model_move(0, 3);
        @(negedge clk);
        bus.move_valid = 1'b0;
        check("grid_after_b2b_err", bus.grid, model_grid());

        // full board, no line
        start_game();
        seq = '{0, 1, 2, 5, 4, 8, 6, 10, 9};
        play_seq(2);
        check("draw_game_status", bus.status, 3);
        check("draw_game_win_line", bus.win_line, 15);

        // ninth move completes column 0
        start_game();
        seq = '{0, 1, 2, 5, 4, 6, 9, 10, 8};
        play_seq(0);
        check("ninth_win_status", bus.status, 1);
        check("ninth_win_line", bus.win_line, 3);

        // renderer stalls 100 cycles while moves and new_game are presented
        start_game();
        issue_move(1, 1, legal);
        wait_draw_req();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            bus.move_valid = i[0];
            bus.move_row   = 2'd0;
            bus.move_col   = 2'd2;
            bus.new_game   = (i % 17 == 3);
            check("stall_draw_req", bus.draw_req, 1);
            check("stall_grid", bus.grid, model_grid());
        end
        bus.move_valid = 1'b0; bus.new_game = 1'b0;
        bus.draw_done = 1'b1;
        @(negedge clk);
        bus.draw_done = 1'b0;
        check("stall_release_ready", bus.move_ready, 1);
        check("stall_release_req", bus.draw_req, 0);

        // random games
        repeat (6) begin
            start_game();
            for (int a = 0; a < 25 && m_status == 2'd0; a++) begin
                issue_move($urandom_range(0, 3), $urandom_range(0, 3), legal);
                if (legal) serve_draw($urandom_range(0, 5));
            end
        end

        // asynchronous reset during DRAW, then new_game beats a move
        start_game();
        issue_move(0, 0, legal);
        wait_draw_req();
        #2 reset = 1'b1;
        model_new_game();
        #1;
        check("async_rst_draw_req", bus.draw_req, 0);
        check("async_rst_ready", bus.move_ready, 1);
        check("async_rst_grid", bus.grid, 0);
        check("async_rst_status", bus.status, 0);
        check("async_rst_win_line", bus.win_line, 15);
        check("async_rst_turn", bus.turn, FP);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        bus.new_game = 1'b1; bus.move_valid = 1'b1;
        bus.move_row = 2'd0; bus.move_col = 2'd0;
        push_draw();
        @(negedge clk);
        bus.new_game = 1'b0; bus.move_valid = 1'b0;
        check("ng_beats_move_grid", bus.grid, 0);
        check("ng_beats_move_req", bus.draw_req, 1);
        serve_draw(0);

        repeat (3) @(negedge clk);
        check("draw_q_leftover", draw_q.size(), 0);
        check("err_q_leftover", err_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/board_controller.md
# board_controller

Game-state owner for the 3×3 tic-tac-toe board, directly upstream of the cell renderer that scans the grid and emits pixel x/y/colour. Accepts validated player moves, writes the 2-bit cell grid, alternates turns, detects win/draw, and handshakes with the renderer so each board change is fully drawn before the next move is accepted.

## Interface
Parameters
- FIRST_PLAYER, 1'b0, side that moves first after reset or new game (0 = X, 1 = O).

Ports
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- move_valid  in  1  a move is presented on move_row/move_col.
- move_row  in  2  target row 0..2.
- move_col  in  2  target column 0..2.
- move_ready  out  1  controller accepts a move this cycle.
- new_game  in  1  clear board and restart; level-sampled.
- grid  out  18  packed board; cell (i,j) at bits [2k+1:2k], k = 3i+j; 00 empty, 01 X, 10 O, 11 unused.
- turn  out  1  side to move (0 = X, 1 = O).
- status  out  2  00 playing, 01 X wins, 10 O wins, 11 draw.
- win_line  out  4  0–2 rows, 3–5 columns, 6 main diagonal, 7 anti-diagonal, 15 none.
- move_err  out  1  one-cycle pulse: last presented move rejected.
- draw_req  out  1  renderer must complete a full pass of the current grid.
- draw_done  in  1  renderer finished the pass requested.

## Operation
- States: PLAY, EVAL, DRAW, OVER.
- PLAY: move_ready = 1. On new_game = 1: clear grid, turn = FIRST_PLAYER, status = 00, win_line = 15, move count = 0, go DRAW; new_game wins over a simultaneous move_valid. Else on move_valid: if row > 2, col > 2 or cell nonzero, pulse move_err and stay in PLAY; otherwise write turn's code (01/10) into the cell, increment move count, go EVAL.
- EVAL: check all 8 lines for three equal nonzero cells. Win sets status to the winner's code and win_line to the lowest matching index. No win and count = 9 sets status = 11. Still playing toggles turn; otherwise turn holds. Go DRAW.
- DRAW: draw_req = 1. Hold until draw_done is sampled high, then go PLAY if status = 00, else OVER. move_valid and new_game are ignored.
- OVER: move_ready = 0; move_valid is ignored with no move_err. new_game behaves as in PLAY.
- Move count is 4 bits and saturates at 9; a full board cannot accept a move, so 9 is never exceeded.
- Outputs held outside listed updates. move_ready and draw_req are decoded from state only.

## Timing
- Reset values: state PLAY, grid 0, turn FIRST_PLAYER, status 00, win_line 15, move_err 0, draw_req 0, move_ready 1, count 0.
- A move is accepted at edge N with move_valid & move_ready high. grid updates after edge N. status, turn and win_line update after edge N+1. draw_req is high from cycle N+2.
- move_err is registered: high for exactly the cycle after the rejecting edge. Back-to-back illegal moves give one pulse per edge.
- draw_done high in the first DRAW cycle exits after one cycle. A draw_done seen outside DRAW is ignored.
- Minimum move-to-move spacing is 3 cycles.
- Reset asserted mid-operation (e.g. during DRAW) returns to the reset values immediately and asynchronously. draw_req drops without waiting for draw_done.

## Structure
- Shared package: cell codes (EMPTY, CELL_X, CELL_O), status codes, win_line codes including WIN_NONE = 15, state enum.
- One natural sub-module: line_checker. It is combinational and maps an 18-bit grid to {win, winner, win_line}. It is reused by the renderer for highlighting.

## Test plan
- Reset, then X (0,0), O (1,1), X (0,1), O (2,2), X (0,2), with draw_done returned 5 cycles after each draw_req. After the last move expect status = 01, win_line = 0, OVER, move_ready = 0.
- Move to occupied (1,1), then to row = 3. Expect a one-cycle move_err each time, grid unchanged, turn unchanged.
- Fill the board with no line: X (0,0), O (0,1), X (0,2), O (1,1), X (1,0), O (2,0), X (1,2), O (2,2), X (2,1). Expect status = 11, win_line = 15.
- Ninth move completes a line. Expect a win status, not 11.
- Hold draw_done low for 100 cycles with move_valid pulsing. Expect draw_req held, no grid change, no move_err. Release draw_done and expect PLAY next cycle.
- Assert reset during DRAW, then new_game and move_valid in the same PLAY cycle. Expect reset values, then a cleared board and DRAW with the move discarded.
